// File: rtl/snes_bus_sync.sv
// SNES bus front end: synchronises and glitch-filters /RD, /WR and /CART, frames
// each bus cycle with start/end pulses, and arbitrates AVR memory slots.
module snes_bus_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int CNT_W       = 8,
  parameter int IDLE_SLOT   = 12
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             SNES_READ,
  input  logic             SNES_WRITE,
  input  logic             SNES_CS,
  input  logic             AVR_REQ,
  input  logic             AVR_REQ_WR,
  output logic             SNES_READs,
  output logic             SNES_WRITEs,
  output logic             SNES_CSs,
  output logic             SNES_RW,
  output logic             CYCLE_START,
  output logic             CYCLE_IS_WRITE,
  output logic             CYCLE_END,
  output logic [CNT_W-1:0] CYCLE_LEN,
  output logic             AVR_GNT,
  output logic             AVR_GNT_WR,
  output logic             BUS_IDLE
);

  localparam int RUN_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(IDLE_SLOT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_RECOVER
  } state_t;

  // bit 0 = /RD, bit 1 = /WR, bit 2 = /CART
  logic [2:0]       pins;
  logic [2:0]       sync_q [SYNC_STAGES];
  logic [2:0]       filt_q;
  logic [RUN_W-1:0] run_q [3];

  assign pins = {SNES_CS, SNES_WRITE, SNES_READ};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= 3'b111;
    end else begin
      sync_q[0] <= pins;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // A filtered bit flips only after FILTER_LEN consecutive disagreeing samples.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      filt_q <= 3'b111;
      for (int i = 0; i < 3; i++) run_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_q[SYNC_STAGES-1][i] == filt_q[i]) begin
          run_q[i] <= '0;
        end else if (run_q[i] == RUN_MAX) begin
          filt_q[i] <= sync_q[SYNC_STAGES-1][i];
          run_q[i]  <= '0;
        end else begin
          run_q[i] <= run_q[i] + 1'b1;
        end
      end
    end
  end

  assign SNES_READs  = filt_q[0];
  assign SNES_WRITEs = filt_q[1];
  assign SNES_CSs    = filt_q[2];
  assign SNES_RW     = filt_q[0] & filt_q[1];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idle_q, idle_d;
  logic             granted_q, granted_d;
  logic             start_d, end_d, is_write_d, gnt_d, gnt_wr_d;
  logic [CNT_W-1:0] cycle_len_d;
  logic             pending;

  assign pending  = AVR_REQ & ~granted_q;
  assign BUS_IDLE = (state_q == ST_IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= ST_IDLE;
      len_q          <= '0;
      idle_q         <= '0;
      granted_q      <= 1'b0;
      CYCLE_START    <= 1'b0;
      CYCLE_END      <= 1'b0;
      CYCLE_IS_WRITE <= 1'b0;
      CYCLE_LEN      <= '0;
      AVR_GNT        <= 1'b0;
      AVR_GNT_WR     <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      idle_q         <= idle_d;
      granted_q      <= granted_d;
      CYCLE_START    <= start_d;
      CYCLE_END      <= end_d;
      CYCLE_IS_WRITE <= is_write_d;
      CYCLE_LEN      <= cycle_len_d;
      AVR_GNT        <= gnt_d;
      AVR_GNT_WR     <= gnt_wr_d;
    end
  end

  // A cycle start always takes the grant, so the idle-slot path can never double-pulse.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    idle_d      = idle_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    is_write_d  = CYCLE_IS_WRITE;
    cycle_len_d = CYCLE_LEN;
    gnt_d       = 1'b0;
    gnt_wr_d    = AVR_GNT_WR;
    unique case (state_q)
      ST_IDLE: begin
        if (!SNES_RW) begin
          state_d    = ST_ACTIVE;
          start_d    = 1'b1;
          is_write_d = ~SNES_WRITEs;
          len_d      = CNT_ONE;
          idle_d     = '0;
          gnt_d      = pending;
        end else if (pending && (idle_q >= SLOT_CNT)) begin
          gnt_d  = 1'b1;
          idle_d = '0;
        end else if (idle_q != CNT_MAX) begin
          idle_d = idle_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (!SNES_RW) begin
          if (len_q != CNT_MAX) len_d = len_q + 1'b1;
        end else begin
          end_d       = 1'b1;
          cycle_len_d = len_q;
          state_d     = ST_RECOVER;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (gnt_d) gnt_wr_d = AVR_REQ_WR;
    granted_d = AVR_REQ & (granted_q | gnt_d);
  end

endmodule
